// File: rtl/deser_8b_32b.sv
// deser_8b_32b: rebuilds BYTES_PER_WORD-byte words from a byte stream
// produced by the matching serializer. Runs entirely in the clk_4f domain.
// A gap in valid_in while a word is partially collected aborts that word
// and raises frame_err for one cycle; a completed word updates data_out
// and raises valid_out for one cycle.
module deser_8b_32b #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                             clk_4f,
    input  logic                             reset,
    input  logic [BYTE_W-1:0]                data_in,
    input  logic                             valid_in,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] data_out,
    output logic                             valid_out,
    output logic                             word_active,
    output logic                             frame_err
);

    // BYTES_PER_WORD must be at least 2 so that a partial-word register exists.
    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int PART_W = BYTE_W * (BYTES_PER_WORD - 1);
    localparam int CNT_W  = (BYTES_PER_WORD > 2) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

    // IDLE mirrors cnt==0, COLLECT mirrors cnt!=0.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PART_W-1:0] part_p0;

    // Append one byte to the partial word. MSB-first shifts older bytes up
    // and drops the new byte in the low slot; LSB-first shifts older bytes
    // down and drops the new byte in the high slot, so after the last byte
    // the first byte sits in bits [BYTE_W-1:0].
    function automatic logic [PART_W-1:0] append_byte(
        input logic [PART_W-1:0] part,
        input logic [BYTE_W-1:0] b
    );
        logic [PART_W-1:0] r;
        if (MSB_FIRST) begin
            r = (part << BYTE_W) | PART_W'(b);
        end else begin
            r = (part >> BYTE_W) | (PART_W'(b) << (PART_W - BYTE_W));
        end
        return r;
    endfunction

    // Combine the buffered bytes with the final byte into a full word.
    function automatic logic [WORD_W-1:0] finish_word(
        input logic [PART_W-1:0] part,
        input logic [BYTE_W-1:0] b
    );
        logic [WORD_W-1:0] w;
        if (MSB_FIRST) begin
            w = {part, b};
        end else begin
            w = {b, part};
        end
        return w;
    endfunction

    // Byte collection FSM with registered word, strobe and status outputs.
    // data_in is only looked at when valid_in is high, so garbage on an idle
    // bus never reaches any register.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            part_p0     <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            word_active <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            if (valid_in) begin
                if (cnt == LAST_CNT) begin
                    // Final byte: publish the word, no dead cycle before the next one.
                    data_out    <= finish_word(part_p0, data_in);
                    valid_out   <= 1'b1;
                    part_p0     <= '0;
                    cnt         <= '0;
                    state       <= IDLE;
                    word_active <= 1'b0;
                end else begin
                    part_p0     <= append_byte(part_p0, data_in);
                    cnt         <= cnt + CNT_W'(1);
                    state       <= COLLECT;
                    word_active <= 1'b1;
                end
            end else begin
                case (state)
                    COLLECT: begin
                        // Gap inside a word: drop the partial bytes, keep data_out.
                        frame_err   <= 1'b1;
                        part_p0     <= '0;
                        cnt         <= '0;
                        state       <= IDLE;
                        word_active <= 1'b0;
                    end
                    default: begin
                        state       <= IDLE;
                        word_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
